// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Purpose  : Multi-cycle RV32M multiply/divide unit for the execute stage.
//            Operand magnitudes are latched on accept. A shift-add multiplier
//            or a restoring divider then runs for 32 iterations, and the
//            result sign is applied when the result is presented.
//            While an operation is in flight, busy stalls the upstream stages.
// Ports    : clk         - rising-edge clock
//            reset       - asynchronous, active-low reset
//            in_valid    - ID/EX holds an M-extension op
//            in_funct3   - operation select (MUL..REMU)
//            in_rs1/rs2  - operands
//            in_rd       - destination register
//            flush       - kill any in-flight operation
//            busy        - stall request (combinational)
//            out_valid   - one-cycle result pulse
//            out_result  - result (holds after the pulse)
//            out_rd      - destination of the result (holds after the pulse)
// Config   : `define MULDIV_FAST_MUL_EN selects a single-cycle combinational
//            product for all MUL* ops. In that build the MUL state does not
//            exist.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_rs1,
   input  logic [31:0] in_rs2,
   input  logic [4:0]  in_rd,
   input  logic        flush,
   output logic        busy,
   output logic        out_valid,
   output logic [31:0] out_result,
   output logic [4:0]  out_rd
);

`ifdef MULDIV_FAST_MUL_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;
`endif

   state_t      state_q, state_d;
   logic [5:0]  cnt_q,   cnt_d;
   logic [63:0] acc_q,   acc_d;    // multiply: {partial hi, multiplier}; divide: {remainder, dividend/quotient}
   logic [31:0] bmag_q,  bmag_d;
   logic [2:0]  op_q,    op_d;
   logic [4:0]  rd_q,    rd_d;
   logic        neg_q,   neg_d;
   logic [31:0] res_q,   res_d;
   logic [4:0]  ord_q,   ord_d;

   // ------------------------------------------------------------------------
   // Accept-time operand conditioning
   // ------------------------------------------------------------------------
   logic        w_a_signed, w_b_signed, w_sa, w_sb;
   logic [31:0] w_a_mag, w_b_mag;
   logic        w_ovf;

   assign w_a_signed = (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                       (in_funct3 == 3'b100) || (in_funct3 == 3'b110);
   assign w_b_signed = (in_funct3 == 3'b001) || (in_funct3 == 3'b100) ||
                       (in_funct3 == 3'b110);
   assign w_sa       = in_rs1[31] & w_a_signed;
   assign w_sb       = in_rs2[31] & w_b_signed;
   assign w_a_mag    = w_sa ? (32'd0 - in_rs1) : in_rs1;
   assign w_b_mag    = w_sb ? (32'd0 - in_rs2) : in_rs2;
   // Signed DIV/REM only (funct3[0]=0 within the divide group)
   assign w_ovf      = ~in_funct3[0] && (in_rs1 == 32'h8000_0000) &&
                       (in_rs2 == 32'hFFFF_FFFF);

`ifdef MULDIV_FAST_MUL_EN
   logic [63:0] w_fast_prod;
   assign w_fast_prod = {32'd0, w_a_mag} * {32'd0, w_b_mag};
`else
   // One shift-add step. Add the multiplicand into the high half when the
   // multiplier LSB is set, then shift the whole accumulator right. After 32
   // steps the accumulator holds the full product.
   logic [32:0] w_mul_sum;
   logic [63:0] w_mul_step;
   assign w_mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, bmag_q} : 33'd0);
   assign w_mul_step = {w_mul_sum, acc_q[31:1]};
`endif

   // One restoring-divide step. The remainder is always below the divisor,
   // so the shifted value fits in 33 bits and the difference fits in 32.
   logic [32:0] w_div_sh;
   logic        w_div_ge;
   logic [31:0] w_div_sub, w_div_rem;
   logic [63:0] w_div_step;
   assign w_div_sh   = {acc_q[63:32], acc_q[31]};
   assign w_div_ge   = w_div_sh >= {1'b0, bmag_q};
   assign w_div_sub  = w_div_sh[31:0] - bmag_q;
   assign w_div_rem  = w_div_ge ? w_div_sub : w_div_sh[31:0];
   assign w_div_step = {w_div_rem, acc_q[30:0], w_div_ge};

   // ------------------------------------------------------------------------
   // Final sign correction and result selection
   // ------------------------------------------------------------------------
   logic [63:0] w_prod_fix;
   logic [31:0] w_quo_fix, w_rem_fix, w_final;
   assign w_prod_fix = neg_q ? (64'd0 - acc_q) : acc_q;
   assign w_quo_fix  = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
   assign w_rem_fix  = neg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

   always_comb begin
      w_final = w_rem_fix;
      case (op_q)
         3'b000:                 w_final = w_prod_fix[31:0];
         3'b001, 3'b010, 3'b011: w_final = w_prod_fix[63:32];
         3'b100, 3'b101:         w_final = w_quo_fix;
         default:                w_final = w_rem_fix;
      endcase
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      bmag_d  = bmag_q;
      op_d    = op_q;
      rd_d    = rd_q;
      neg_d   = neg_q;
      res_d   = res_q;
      ord_d   = ord_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && !flush) begin
               op_d   = in_funct3;
               rd_d   = in_rd;
               cnt_d  = 6'd0;
               bmag_d = w_b_mag;
               // Remainder takes the dividend sign; product and quotient take the xor
               neg_d  = (in_funct3[2] && in_funct3[1]) ? w_sa : (w_sa ^ w_sb);
               if (!in_funct3[2]) begin
`ifdef MULDIV_FAST_MUL_EN
                  acc_d   = w_fast_prod;
                  state_d = S_DONE;
`else
                  acc_d   = {32'd0, w_a_mag};
                  state_d = S_MUL;
`endif
               end else if (in_rs2 == 32'd0) begin
                  // Raw dividend as remainder, all-ones quotient, no sign fix
                  acc_d   = {in_rs1, 32'hFFFF_FFFF};
                  neg_d   = 1'b0;
                  state_d = S_DONE;
               end else if (w_ovf) begin
                  acc_d   = {32'd0, 32'h8000_0000};
                  neg_d   = 1'b0;
                  state_d = S_DONE;
               end else begin
                  acc_d   = {32'd0, w_a_mag};
                  state_d = S_DIV;
               end
            end
         end
`ifndef MULDIV_FAST_MUL_EN
         S_MUL: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = w_mul_step;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) state_d = S_DONE;
            end
         end
`endif
         S_DIV: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = w_div_step;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (!flush) begin
               res_d = w_final;
               ord_d = rd_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 6'd0;
         acc_q   <= 64'd0;
         bmag_q  <= 32'd0;
         op_q    <= 3'd0;
         rd_q    <= 5'd0;
         neg_q   <= 1'b0;
         res_q   <= 32'd0;
         ord_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         bmag_q  <= bmag_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
         ord_q   <= ord_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs. The result is driven straight from the datapath during DONE and
   // from the holding registers afterwards, so it is valid with the pulse.
   // ------------------------------------------------------------------------
   logic w_done_fire;
   assign w_done_fire = (state_q == S_DONE) && !flush;
   assign out_valid   = w_done_fire;
   assign out_result  = w_done_fire ? w_final : res_q;
   assign out_rd      = w_done_fire ? rd_q    : ord_q;

   always_comb begin
      busy = 1'b0;
      case (state_q)
         S_IDLE:  busy = in_valid && !flush;
         S_DONE:  busy = 1'b0;
         default: busy = 1'b1;
      endcase
      if (!reset) busy = 1'b0;
   end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_unit
// Purpose  : Directed self-checking bench for ex_muldiv_unit
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [2:0]  in_funct3 = 3'd0;
   logic [31:0] in_rs1 = 32'd0;
   logic [31:0] in_rs2 = 32'd0;
   logic [4:0]  in_rd = 5'd0;
   logic        flush = 1'b0;
   logic        busy;
   logic        out_valid;
   logic [31:0] out_result;
   logic [4:0]  out_rd;

   int n_vec = 0;
   int n_err = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int       MUL_LAT   = 1;
   localparam int       MUL_BUSY  = 1;
   localparam bit [2:0] ABORT_OP  = 3'b101;
`else
   localparam int       MUL_LAT   = 33;
   localparam int       MUL_BUSY  = 33;
   localparam bit [2:0] ABORT_OP  = 3'b000;
`endif

   ex_muldiv_unit dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_funct3  (in_funct3),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_rd      (in_rd),
      .flush      (flush),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_result (out_result),
      .out_rd     (out_rd)
   );

   always #5 clk = ~clk;

   // Presents one op at a negedge (cycle 0) and holds it until the result
   // pulse. Reports the pulse cycle, the number of busy cycles and the result.
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output int nbusy,
                        output logic [31:0] res, output logic [4:0] ord);
      int cyc;
      @(negedge clk);
      in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_rd = rd;
      cyc = 0; nbusy = 0; lat = -1; res = 32'hDEAD_BEEF; ord = 5'd0;
      while (1) begin
         #1;
         if (busy) nbusy++;
         if (out_valid) begin
            lat = cyc; res = out_result; ord = out_rd;
            break;
         end
         if (cyc >= 60) break;
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      in_valid = 1'b1; in_funct3 = 3'b100; in_rs1 = 32'd9; in_rs2 = 32'd3;
      #12;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      n_vec++; if (out_result !== 32'd0) begin n_err++; $display("FAIL reset_result got=%h exp=00000000", out_result); end
      n_vec++; if (out_rd !== 5'd0) begin n_err++; $display("FAIL reset_rd got=%0d exp=0", out_rd); end
      in_valid = 1'b0;
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_div_signed();
      int lat, nb; logic [31:0] r; logic [4:0] d;
      do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3, lat, nb, r, d);
      n_vec++; if (lat != 33) begin n_err++; $display("FAIL div_lat got=%0d exp=33", lat); end
      n_vec++; if (nb != 33) begin n_err++; $display("FAIL div_busy_cycles got=%0d exp=33", nb); end
      n_vec++; if (r !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_result got=%h exp=fffffffd", r); end
      n_vec++; if (d !== 5'd3) begin n_err++; $display("FAIL div_rd got=%0d exp=3", d); end
      do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd4, lat, nb, r, d);
      n_vec++; if (lat != 33) begin n_err++; $display("FAIL rem_lat got=%0d exp=33", lat); end
      n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rem_result got=%h exp=ffffffff", r); end
   endtask

   task automatic test_div_zero();
      int lat, nb; logic [31:0] r; logic [4:0] d;
      do_op(3'b101, 32'd5, 32'd0, 5'd5, lat, nb, r, d);
      n_vec++; if (lat != 1) begin n_err++; $display("FAIL divu0_lat got=%0d exp=1", lat); end
      n_vec++; if (nb != 1) begin n_err++; $display("FAIL divu0_busy_cycles got=%0d exp=1", nb); end
      n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divu0_result got=%h exp=ffffffff", r); end
      do_op(3'b111, 32'd5, 32'd0, 5'd6, lat, nb, r, d);
      n_vec++; if (r !== 32'd5) begin n_err++; $display("FAIL remu0_result got=%h exp=00000005", r); end
      n_vec++; if (d !== 5'd6) begin n_err++; $display("FAIL remu0_rd got=%0d exp=6", d); end
   endtask

   task automatic test_overflow();
      int lat, nb; logic [31:0] r; logic [4:0] d;
      do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, lat, nb, r, d);
      n_vec++; if (lat != 1) begin n_err++; $display("FAIL ovf_lat got=%0d exp=1", lat); end
      n_vec++; if (r !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_div got=%h exp=80000000", r); end
      do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, lat, nb, r, d);
      n_vec++; if (r !== 32'd0) begin n_err++; $display("FAIL ovf_rem got=%h exp=00000000", r); end
   endtask

   task automatic test_mul();
      int lat, nb; logic [31:0] r; logic [4:0] d;
      do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd10, lat, nb, r, d);
      n_vec++; if (lat != MUL_LAT) begin n_err++; $display("FAIL mulh_lat got=%0d exp=%0d", lat, MUL_LAT); end
      n_vec++; if (nb != MUL_BUSY) begin n_err++; $display("FAIL mulh_busy_cycles got=%0d exp=%0d", nb, MUL_BUSY); end
      n_vec++; if (r !== 32'h4000_0000) begin n_err++; $display("FAIL mulh_result got=%h exp=40000000", r); end
      do_op(3'b000, 32'h8000_0000, 32'h8000_0000, 5'd11, lat, nb, r, d);
      n_vec++; if (r !== 32'd0) begin n_err++; $display("FAIL mul_result got=%h exp=00000000", r); end
      do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, lat, nb, r, d);
      n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mulhsu_result got=%h exp=ffffffff", r); end
      do_op(3'b000, 32'hFFFF_FFFD, 32'd7, 5'd13, lat, nb, r, d);
      n_vec++; if (r !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_neg_result got=%h exp=ffffffeb", r); end
   endtask

   task automatic test_hold();
      int lat, nb; logic [31:0] r; logic [4:0] d;
      do_op(3'b101, 32'd1000, 32'd7, 5'd14, lat, nb, r, d);
      n_vec++; if (r !== 32'd142) begin n_err++; $display("FAIL divu_result got=%0d exp=142", r); end
      @(negedge clk); #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_valid got=%b exp=0", out_valid); end
      n_vec++; if (out_result !== 32'd142) begin n_err++; $display("FAIL hold_result got=%0d exp=142", out_result); end
      n_vec++; if (out_rd !== 5'd14) begin n_err++; $display("FAIL hold_rd got=%0d exp=14", out_rd); end
   endtask

   task automatic test_flush();
      int lat, nb, seen; logic [31:0] r; logic [4:0] d;
      seen = 0;
      @(negedge clk);
      in_valid = 1'b1; in_funct3 = 3'b100; in_rs1 = 32'd1000; in_rs2 = 32'd3; in_rd = 5'd15;
      for (int c = 0; c < 10; c++) begin
         #1; if (out_valid) seen++;
         @(negedge clk);
      end
      flush = 1'b1; in_valid = 1'b0;
      #1; if (out_valid) seen++;
      @(negedge clk);
      flush = 1'b0;
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_idle_busy got=%b exp=0", busy); end
      for (int c = 0; c < 40; c++) begin
         if (out_valid) seen++;
         @(negedge clk); #1;
      end
      n_vec++; if (seen != 0) begin n_err++; $display("FAIL flush_no_valid got=%0d pulses exp=0", seen); end
      do_op(3'b011, 32'hFFFF_FFFF, 32'd2, 5'd7, lat, nb, r, d);
      n_vec++; if (lat != MUL_LAT) begin n_err++; $display("FAIL mulhu_lat got=%0d exp=%0d", lat, MUL_LAT); end
      n_vec++; if (r !== 32'd1) begin n_err++; $display("FAIL mulhu_result got=%h exp=00000001", r); end
   endtask

   task automatic test_reset_mid();
      int lat, nb; logic [31:0] r; logic [4:0] d;
      @(negedge clk);
      in_valid = 1'b1; in_funct3 = ABORT_OP; in_rs1 = 32'd3; in_rs2 = 32'd5; in_rd = 5'd9;
      repeat (5) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
      n_vec++; if (out_result !== 32'd0) begin n_err++; $display("FAIL rstmid_result got=%h exp=00000000", out_result); end
      n_vec++; if (out_rd !== 5'd0) begin n_err++; $display("FAIL rstmid_rd got=%0d exp=0", out_rd); end
      in_valid = 1'b0;
      @(negedge clk); reset = 1'b1;
      do_op(3'b101, 32'd100, 32'd7, 5'd4, lat, nb, r, d);
      n_vec++; if (lat != 33) begin n_err++; $display("FAIL rstmid_divu_lat got=%0d exp=33", lat); end
      n_vec++; if (r !== 32'd14) begin n_err++; $display("FAIL rstmid_divu_result got=%0d exp=14", r); end
      n_vec++; if (d !== 5'd4) begin n_err++; $display("FAIL rstmid_divu_rd got=%0d exp=4", d); end
   endtask

   initial begin
      test_reset();
      test_div_signed();
      test_div_zero();
      test_overflow();
      test_mul();
      test_hold();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
